// File: rtl/npc_commit_seq.sv
// ---------------------------------------------------------------------------
// npc_commit_seq
//
// Purpose:
//   Multi-cycle instruction sequencer for a simple non-pipelined core. It walks
//   each instruction through FETCH -> EXEC -> (MEM) -> WB. It commits the next
//   PC and pulses write_back once per instruction. Fetch and memory handshakes
//   are guarded by a timeout counter; a timeout or an illegal load+store decode
//   parks the sequencer in FAULT. An ebreak parks it in HALT after its commit.
//   HALT and FAULT hold until rst.
//
// Parameters:
//   PC_W      PC / next-PC width
//   RESET_PC  PC value loaded on reset
//   TO_W      timeout counter width; a handshake faults after 2^TO_W-1
//             unanswered cycles
//   PERF_W    width of cycle_cnt / instret (both wrap)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   ifu_valid    fetched-instruction pulse from IFU (honoured only in FETCH)
//   mem_ren      decoded load   (sampled in EXEC)
//   mem_wen      decoded store  (sampled in EXEC)
//   lsu_done     load/store completion pulse (honoured only in MEM)
//   halt_in      decoded ebreak (sampled in EXEC)
//   npc_in       next PC from EXU (sampled in WB)
//   ifu_req      high throughout FETCH
//   lsu_req      high throughout MEM
//   pc           architectural PC of the current instruction
//   write_back   one-cycle commit strobe (the WB cycle)
//   halt         high in HALT or FAULT
//   fault        high in FAULT
//   fault_cause  0 none, 1 fetch timeout, 2 memory timeout, 3 ren&wen
//   cycle_cnt    cycles spent in FETCH/EXEC/MEM/WB
//   instret      committed instruction count
// ---------------------------------------------------------------------------
module npc_commit_seq #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int              TO_W     = 8,
  parameter int              PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              lsu_done,
  input  logic              halt_in,
  input  logic [PC_W-1:0]   npc_in,
  output logic              ifu_req,
  output logic              lsu_req,
  output logic [PC_W-1:0]   pc,
  output logic              write_back,
  output logic              halt,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_FETCH  = 2'd1;
  localparam logic [1:0] CAUSE_MEM    = 2'd2;
  localparam logic [1:0] CAUSE_RWBOTH = 2'd3;

  // The counter holds the number of unanswered cycles before the current one.
  // When it reads 2^TO_W-2, the current cycle is the (2^TO_W-1)-th unanswered
  // cycle. That cycle is the limit: a response in it still wins, and silence
  // in it faults.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic              halt_pend_q;
  logic [PC_W-1:0]   pc_q;
  logic [1:0]        cause_q, cause_d;
  logic [PERF_W-1:0] cycle_q;
  logic [PERF_W-1:0] instret_q;

  logic              to_clr;
  logic              to_inc;
  logic              hp_set;
  logic              active;

  // Next-state decode. Requests are answered on the cycle after the response
  // is seen, so every response is sampled by the state register alone.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    to_clr  = 1'b0;
    to_inc  = 1'b0;
    hp_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        to_clr  = 1'b1;
      end
      S_FETCH: begin
        if (ifu_valid) begin
          state_d = S_EXEC;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          cause_d = CAUSE_FETCH;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_EXEC: begin
        if (mem_ren && mem_wen) begin
          state_d = S_FAULT;
          cause_d = CAUSE_RWBOTH;
        end else if (halt_in) begin
          state_d = S_WB;
          hp_set  = 1'b1;
        end else if (mem_ren || mem_wen) begin
          state_d = S_MEM;
          to_clr  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_done) begin
          state_d = S_WB;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          cause_d = CAUSE_MEM;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_WB: begin
        if (halt_pend_q) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          to_clr  = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign active = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)   || (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      halt_pend_q <= 1'b0;
      pc_q        <= RESET_PC;
      cause_q     <= CAUSE_NONE;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (to_clr) begin
        to_cnt_q <= '0;
      end else if (to_inc) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (hp_set) begin
        halt_pend_q <= 1'b1;
      end
      if (state_q == S_WB) begin
        pc_q      <= npc_in;
        instret_q <= instret_q + PERF_W'(1);
      end
      if (active) begin
        cycle_q <= cycle_q + PERF_W'(1);
      end
    end
  end

  // All outputs are state decodes or register copies.
  assign ifu_req     = (state_q == S_FETCH);
  assign lsu_req     = (state_q == S_MEM);
  assign write_back  = (state_q == S_WB);
  assign halt        = (state_q == S_HALT) || (state_q == S_FAULT);
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = cause_q;
  assign pc          = pc_q;
  assign cycle_cnt   = cycle_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_npc_commit_seq.sv
module tb_npc_commit_seq;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic        mem_ren;
  logic        mem_wen;
  logic        lsu_done;
  logic        halt_in;
  logic [31:0] npc_in;
  logic        ifu_req;
  logic        lsu_req;
  logic [31:0] pc;
  logic        write_back;
  logic        halt;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] instret;

  int checks;
  int failures;

  npc_commit_seq #(
    .PC_W    (32),
    .RESET_PC(32'h8000_0000),
    .TO_W    (3),
    .PERF_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_valid  (ifu_valid),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .lsu_done   (lsu_done),
    .halt_in    (halt_in),
    .npc_in     (npc_in),
    .ifu_req    (ifu_req),
    .lsu_req    (lsu_req),
    .pc         (pc),
    .write_back (write_back),
    .halt       (halt),
    .fault      (fault),
    .fault_cause(fault_cause),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, ren, wen, ld, hin;
    logic [31:0] npc;
    logic        e_ifu, e_lsu, e_wb, e_halt, e_fault;
    logic [1:0]  e_cause;
    logic [31:0] e_pc, e_ir, e_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, iv, ren, wen, ld, hin, input logic [31:0] npc,
                   input logic e_ifu, e_lsu, e_wb, e_halt, e_fault,
                   input logic [1:0] e_cause, input logic [31:0] e_pc, e_ir, e_cyc);
    vec_t t;
    t.rst = r; t.iv = iv; t.ren = ren; t.wen = wen; t.ld = ld; t.hin = hin; t.npc = npc;
    t.e_ifu = e_ifu; t.e_lsu = e_lsu; t.e_wb = e_wb; t.e_halt = e_halt; t.e_fault = e_fault;
    t.e_cause = e_cause; t.e_pc = e_pc; t.e_ir = e_ir; t.e_cyc = e_cyc;
    vecs.push_back(t);
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic r, iv, ren, wen, ld, hin, input logic [31:0] npc);
    @(negedge clk);
    rst = r; ifu_valid = iv; mem_ren = ren; mem_wen = wen;
    lsu_done = ld; halt_in = hin; npc_in = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic e_ifu, e_lsu, e_wb, e_halt, e_fault,
                           input logic [1:0] e_cause, input logic [31:0] e_pc, e_ir, e_cyc);
    checks++;
    if ({ifu_req, lsu_req, write_back, halt, fault, fault_cause, pc, instret, cycle_cnt} !==
        {e_ifu, e_lsu, e_wb, e_halt, e_fault, e_cause, e_pc, e_ir, e_cyc}) begin
      failures++;
      $display("FAIL %s: got ifu=%b lsu=%b wb=%b halt=%b fault=%b cause=%0d pc=%h ir=%0d cyc=%0d ; want ifu=%b lsu=%b wb=%b halt=%b fault=%b cause=%0d pc=%h ir=%0d cyc=%0d",
               name, ifu_req, lsu_req, write_back, halt, fault, fault_cause, pc, instret, cycle_cnt,
               e_ifu, e_lsu, e_wb, e_halt, e_fault, e_cause, e_pc, e_ir, e_cyc);
    end
  endtask

  localparam logic [31:0] RP = 32'h8000_0000;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; ifu_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    lsu_done = 1'b0; halt_in = 1'b0; npc_in = '0;

    //  rst iv rn wn ld hi npc          ifu lsu wb h f cause pc   ir cyc
    // ALU instruction; ifu_valid during reset and IDLE is ignored
    v(1, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,              0, 0, 1, 0, 0, 0, RP, 0, 2);
    v(0, 0, 0, 0, 0, 0, 32'h8000_0004,  1, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 3);
    // load, lsu_done in 4th MEM cycle; stray lsu_done in FETCH ignored
    v(0, 1, 0, 0, 1, 0, 0,              0, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 4);
    v(0, 0, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 5);
    v(0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 6);
    v(0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 7);
    v(0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 8);
    v(0, 0, 0, 0, 1, 0, 0,              0, 0, 1, 0, 0, 0, 32'h8000_0004, 1, 9);
    v(0, 0, 0, 0, 0, 0, 32'h8000_0008,  1, 0, 0, 0, 0, 0, 32'h8000_0008, 2, 10);
    // ren&wen in EXEC -> FAULT cause 3, no write_back, frozen afterwards
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 32'h8000_0008, 2, 11);
    v(0, 0, 1, 1, 0, 0, 0,              0, 0, 0, 1, 1, 3, 32'h8000_0008, 2, 12);
    v(0, 1, 0, 0, 1, 0, 32'h1234_0000,  0, 0, 0, 1, 1, 3, 32'h8000_0008, 2, 12);
    v(1, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, RP, 0, 0);
    // ebreak: one commit then HALT, later pulses ignored
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 1);
    v(0, 0, 0, 0, 0, 1, 0,              0, 0, 1, 0, 0, 0, RP, 0, 2);
    v(0, 0, 0, 0, 0, 0, 32'h8000_0100,  0, 0, 0, 1, 0, 0, 32'h8000_0100, 1, 3);
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 1, 0, 0, 32'h8000_0100, 1, 3);
    v(0, 0, 0, 0, 1, 0, 0,              0, 0, 0, 1, 0, 0, 32'h8000_0100, 1, 3);
    // rst pulse mid-MEM
    v(1, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 1);
    v(0, 0, 0, 1, 0, 0, 0,              0, 1, 0, 0, 0, 0, RP, 0, 2);
    v(0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, RP, 0, 3);
    v(1, 0, 0, 0, 1, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0,              1, 0, 0, 0, 0, 0, RP, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, RP, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,              0, 0, 1, 0, 0, 0, RP, 0, 2);
    v(0, 0, 0, 0, 0, 0, 32'h8000_0004,  1, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 3);
    // lsu_done on the limit (7th) MEM cycle wins over the timeout
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 4);
    v(0, 0, 1, 0, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 5);
    for (int i = 0; i < 6; i++)
      v(0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 32'h8000_0004, 1, 32'(6 + i));
    v(0, 0, 0, 0, 1, 0, 0,              0, 0, 1, 0, 0, 0, 32'h8000_0004, 1, 12);
    v(0, 0, 0, 0, 0, 0, 32'h8000_0008,  1, 0, 0, 0, 0, 0, 32'h8000_0008, 2, 13);
    // silent memory: FAULT cause 2 after 7 MEM cycles
    v(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 32'h8000_0008, 2, 14);
    v(0, 0, 0, 1, 0, 0, 0,              0, 1, 0, 0, 0, 0, 32'h8000_0008, 2, 15);
    for (int i = 0; i < 6; i++)
      v(0, 0, 0, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 32'h8000_0008, 2, 32'(16 + i));
    v(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 1, 1, 2, 32'h8000_0008, 2, 22);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].ren, vecs[i].wen, vecs[i].ld, vecs[i].hin, vecs[i].npc);
      check_all($sformatf("vec%0d", i), vecs[i].e_ifu, vecs[i].e_lsu, vecs[i].e_wb, vecs[i].e_halt,
                vecs[i].e_fault, vecs[i].e_cause, vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_cyc);
    end

    // Fetch timeout: ifu_valid never arrives, 7 FETCH cycles then FAULT cause 1
    step(1, 0, 0, 0, 0, 0, 0);
    check_all("fto_reset", 0, 0, 0, 0, 0, 0, RP, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_all("fto_fetch1", 1, 0, 0, 0, 0, 0, RP, 0, 0);
    for (int i = 1; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check_all($sformatf("fto_fetch%0d", i + 1), 1, 0, 0, 0, 0, 0, RP, 0, 32'(i));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check_all("fto_fault", 0, 0, 0, 1, 1, 1, RP, 0, 7);
    step(0, 1, 0, 0, 1, 0, 0);
    check_all("fto_absorb", 0, 0, 0, 1, 1, 1, RP, 0, 7);

    // ifu_valid on the limit FETCH cycle wins over the timeout
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);
    check_all("flim_fetch7", 1, 0, 0, 0, 0, 0, RP, 0, 6);
    step(0, 1, 0, 0, 0, 0, 0);
    check_all("flim_exec", 0, 0, 0, 0, 0, 0, RP, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0);
    check_all("flim_wb", 0, 0, 1, 0, 0, 0, RP, 0, 8);
    step(0, 0, 0, 0, 0, 0, 32'h8000_0040);
    check_all("flim_commit", 1, 0, 0, 0, 0, 0, 32'h8000_0040, 1, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
